// File: rtl/timer_multichannel_us_if.sv
// Command and status bundle of the multi-channel delay timer: load/abort commands in,
// shared tick plus per-channel busy/done status out.
interface timer_multichannel_us_if #(
    parameter int  CHANNELS = 4,
    parameter int  COUNT_W  = 32,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                load;
    logic [CH_W-1:0]     load_ch;
    logic [COUNT_W-1:0]  load_value;
    logic                load_periodic;
    logic                abort;
    logic [CH_W-1:0]     abort_ch;
    logic                tick;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] done;
    logic                done_any;

    modport master (
        output load, load_ch, load_value, load_periodic, abort, abort_ch,
        input  tick, busy, done, done_any
    );

    modport slave (
        input  load, load_ch, load_value, load_periodic, abort, abort_ch,
        output tick, busy, done, done_any
    );
endinterface

// File: rtl/timer_multichannel_us.sv
// Multi-channel down-counting delay timer sharing one tick prescaler; each channel is
// one-shot or periodic and raises a registered 1-cycle done pulse on expiry.
module timer_multichannel_us #(
    parameter int CLOCK_FREQUENCY_HZ = 200000000,
    parameter int TICK_HZ            = 1000000,
    parameter int CHANNELS           = 4,
    parameter int COUNT_W            = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    timer_multichannel_us_if.slave bus
);
    localparam int DIV_RAW = CLOCK_FREQUENCY_HZ / TICK_HZ;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PS_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

    typedef enum logic {ST_IDLE, ST_RUN} ch_state_e;

    logic [PS_W-1:0]     ps_q, ps_d;
    logic                tick_q, tick_d;
    ch_state_e           state_q  [CHANNELS];
    ch_state_e           state_d  [CHANNELS];
    logic [COUNT_W-1:0]  count_q  [CHANNELS];
    logic [COUNT_W-1:0]  count_d  [CHANNELS];
    logic [COUNT_W-1:0]  reload_q [CHANNELS];
    logic [COUNT_W-1:0]  reload_d [CHANNELS];
    logic [CHANNELS-1:0] periodic_q, periodic_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic                done_any_q, done_any_d;
    logic [CHANNELS-1:0] load_hit, abort_hit, busy;

    // tick_q is registered so it is 0 during reset and lines up with ps_q == DIV-1.
    always_comb begin
        ps_d   = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
        tick_d = (ps_d == PS_LAST);
    end

    // Out-of-range channel numbers never match any i, so such commands fall through.
    always_comb begin
        load_hit  = '0;
        abort_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            load_hit[i]  = bus.load  && (int'(bus.load_ch)  == i);
            abort_hit[i] = bus.abort && (int'(bus.abort_ch) == i);
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the branches infers a latch.
        done_d     = '0;
        periodic_d = periodic_q;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            count_d[i]  = count_q[i];
            reload_d[i] = reload_q[i];
            if (abort_hit[i]) begin
                state_d[i] = ST_IDLE;
                count_d[i] = '0;
            end else if (load_hit[i]) begin
                if (bus.load_value == '0) begin
                    state_d[i] = ST_IDLE;
                    count_d[i] = '0;
                end else begin
                    state_d[i]    = ST_RUN;
                    count_d[i]    = bus.load_value;
                    reload_d[i]   = bus.load_value;
                    periodic_d[i] = bus.load_periodic;
                end
            end else if (state_q[i] == ST_RUN && tick_q && count_q[i] != '0) begin
                if (count_q[i] == COUNT_W'(1)) begin
                    done_d[i] = 1'b1;
                    if (periodic_q[i]) begin
                        count_d[i] = reload_q[i];
                    end else begin
                        state_d[i] = ST_IDLE;
                        count_d[i] = '0;
                    end
                end else begin
                    count_d[i] = count_q[i] - COUNT_W'(1);
                end
            end
        end
        done_any_d = |done_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_q       <= '0;
            tick_q     <= 1'b0;
            periodic_q <= '0;
            done_q     <= '0;
            done_any_q <= 1'b0;
            // NOTE: per-channel arrays are a handful of flops, not RAM, so they reset like any state.
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= ST_IDLE;
                count_q[i]  <= '0;
                reload_q[i] <= '0;
            end
        end else begin
            ps_q       <= ps_d;
            tick_q     <= tick_d;
            periodic_q <= periodic_d;
            done_q     <= done_d;
            done_any_q <= done_any_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy[i] = (state_q[i] == ST_RUN);
        end
    end

    assign bus.tick     = tick_q;
    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.done_any = done_any_q;
endmodule

// File: tb/tb_timer_multichannel_us.sv
// Directed bench: DUT A runs DIV=10 with 4 channels, DUT B runs DIV=1 with 3 channels
// (so an out-of-range channel number is representable on its 2-bit channel field).
module tb_timer_multichannel_us;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    timer_multichannel_us_if #(.CHANNELS(4), .COUNT_W(32)) ia ();
    timer_multichannel_us_if #(.CHANNELS(3), .COUNT_W(32)) ib ();

    timer_multichannel_us #(
        .CLOCK_FREQUENCY_HZ(10), .TICK_HZ(1), .CHANNELS(4), .COUNT_W(32)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia)
    );

    timer_multichannel_us #(
        .CLOCK_FREQUENCY_HZ(1), .TICK_HZ(1), .CHANNELS(3), .COUNT_W(32)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required normal end");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ia.load = 1'b0; ia.load_ch = '0; ia.load_value = '0; ia.load_periodic = 1'b0;
        ia.abort = 1'b0; ia.abort_ch = '0;
        ib.load = 1'b0; ib.load_ch = '0; ib.load_value = '0; ib.load_periodic = 1'b0;
        ib.abort = 1'b0; ib.abort_ch = '0;
    endtask

    task automatic load_a(input int ch, input int value, input logic periodic);
        ia.load = 1'b1; ia.load_ch = 2'(ch); ia.load_value = 32'(value); ia.load_periodic = periodic;
    endtask

    // Advance until DUT A's tick is high, bounded by 20 cycles.
    task automatic wait_tick();
        int n = 0;
        while (ia.tick !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (ia.tick !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick: tick=%b after %0d cycles, required 1", ia.tick, n);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({ia.tick, ia.busy, ia.done, ia.done_any, ib.tick, ib.busy, ib.done, ib.done_any} !== '0) begin
            errors++;
            $display("FAIL reset_state: a tick/busy/done/any=%b/%b/%b/%b b=%b/%b/%b/%b, required all 0",
                     ia.tick, ia.busy, ia.done, ia.done_any, ib.tick, ib.busy, ib.done, ib.done_any);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cyc();
            checks++;
            if (ia.tick !== (k % 10 == 8)) begin
                errors++;
                $display("FAIL tick_period: cycle %0d tick=%b, required %b", k, ia.tick, (k % 10 == 8));
            end
            checks++;
            if ({ia.busy, ia.done, ia.done_any} !== 9'b0) begin
                errors++;
                $display("FAIL idle_outputs: cycle %0d busy=%b done=%b any=%b, required 0",
                         k, ia.busy, ia.done, ia.done_any);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [3:0] exp_busy, exp_done;
        wait_tick();
        cyc();
        load_a(0, 3, 1'b0);
        for (int j = 1; j <= 40; j++) begin
            cyc();
            if (j == 1) ia.load = 1'b0;
            exp_busy = (j < 30) ? 4'b0001 : 4'b0000;
            exp_done = (j == 30) ? 4'b0001 : 4'b0000;
            checks++;
            if (ia.busy !== exp_busy || ia.done !== exp_done || ia.done_any !== (j == 30)) begin
                errors++;
                $display("FAIL oneshot: offset %0d busy=%b done=%b any=%b, required %b %b %b",
                         j, ia.busy, ia.done, ia.done_any, exp_busy, exp_done, (j == 30));
            end
        end
    endtask

    task automatic test_periodic();
        int pulses = 0;
        wait_tick();
        cyc();
        load_a(1, 2, 1'b1);
        for (int j = 1; j <= 100; j++) begin
            cyc();
            if (j == 1) ia.load = 1'b0;
            if (ia.done[1] === 1'b1) pulses++;
            checks++;
            if (ia.busy !== 4'b0010 || ia.done !== ((j % 20 == 0) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL periodic: offset %0d busy=%b done=%b, required busy 0010 done pulse=%b",
                         j, ia.busy, ia.done, (j % 20 == 0));
            end
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL periodic_count: %0d pulses, required 5", pulses);
        end
        ia.abort = 1'b1;
        ia.abort_ch = 2'd1;
        for (int j = 1; j <= 30; j++) begin
            cyc();
            if (j == 1) ia.abort = 1'b0;
            checks++;
            if (ia.busy !== 4'b0000 || ia.done !== 4'b0000) begin
                errors++;
                $display("FAIL periodic_abort: offset %0d busy=%b done=%b, required 0000 0000",
                         j, ia.busy, ia.done);
            end
        end
    endtask

    task automatic test_back_to_back();
        wait_tick();
        cyc();
        load_a(2, 1, 1'b0);
        cyc();
        load_a(3, 1, 1'b0);
        checks++;
        if (ia.busy !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_first_busy: busy=%b, required 0100", ia.busy);
        end
        for (int j = 2; j <= 15; j++) begin
            cyc();
            if (j == 2) ia.load = 1'b0;
            checks++;
            if (ia.busy !== ((j < 10) ? 4'b1100 : 4'b0000) ||
                ia.done !== ((j == 10) ? 4'b1100 : 4'b0000) || ia.done_any !== (j == 10)) begin
                errors++;
                $display("FAIL back_to_back: offset %0d busy=%b done=%b any=%b, required done 1100 only at 10",
                         j, ia.busy, ia.done, ia.done_any);
            end
        end
    endtask

    task automatic test_corners();
        // Zero load value: channel must stay idle.
        wait_tick();
        cyc();
        load_a(0, 0, 1'b0);
        for (int j = 1; j <= 12; j++) begin
            cyc();
            if (j == 1) ia.load = 1'b0;
            checks++;
            if (ia.busy !== 4'b0000 || ia.done !== 4'b0000) begin
                errors++;
                $display("FAIL load_zero: offset %0d busy=%b done=%b, required 0000 0000", j, ia.busy, ia.done);
            end
        end
        // Abort and load on the same channel in one cycle: abort wins.
        load_a(0, 1, 1'b0);
        ia.abort = 1'b1;
        ia.abort_ch = 2'd0;
        for (int j = 1; j <= 12; j++) begin
            cyc();
            if (j == 1) begin
                ia.load = 1'b0;
                ia.abort = 1'b0;
            end
            checks++;
            if (ia.busy !== 4'b0000 || ia.done !== 4'b0000) begin
                errors++;
                $display("FAIL abort_and_load: offset %0d busy=%b done=%b, required 0000 0000", j, ia.busy, ia.done);
            end
        end
        // Abort coincident with the final tick: no done pulse.
        wait_tick();
        cyc();
        load_a(0, 1, 1'b0);
        for (int j = 1; j <= 9; j++) begin
            cyc();
            if (j == 1) ia.load = 1'b0;
        end
        checks++;
        if (ia.tick !== 1'b1 || ia.busy !== 4'b0001) begin
            errors++;
            $display("FAIL abort_tick_setup: tick=%b busy=%b, required 1 0001", ia.tick, ia.busy);
        end
        ia.abort = 1'b1;
        ia.abort_ch = 2'd0;
        for (int j = 10; j <= 20; j++) begin
            cyc();
            if (j == 10) ia.abort = 1'b0;
            checks++;
            if (ia.busy !== 4'b0000 || ia.done !== 4'b0000 || ia.done_any !== 1'b0) begin
                errors++;
                $display("FAIL abort_final_tick: offset %0d busy=%b done=%b any=%b, required all 0",
                         j, ia.busy, ia.done, ia.done_any);
            end
        end
        // Channel number beyond CHANNELS on the 3-channel instance: ignored.
        ib.load = 1'b1; ib.load_ch = 2'd3; ib.load_value = 32'd5; ib.load_periodic = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            cyc();
            if (j == 1) ib.load = 1'b0;
            checks++;
            if (ib.busy !== 3'b000 || ib.done !== 3'b000 || ib.done_any !== 1'b0) begin
                errors++;
                $display("FAIL bad_channel: offset %0d busy=%b done=%b any=%b, required all 0",
                         j, ib.busy, ib.done, ib.done_any);
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_tick();
        cyc();
        load_a(0, 2, 1'b0);
        for (int j = 1; j <= 12; j++) begin
            cyc();
            if (j == 1) ia.load = 1'b0;
        end
        checks++;
        if (ia.busy !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_setup: busy=%b, required 0001", ia.busy);
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++;
        if ({ia.tick, ia.busy, ia.done, ia.done_any} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid: tick=%b busy=%b done=%b any=%b, required all 0",
                     ia.tick, ia.busy, ia.done, ia.done_any);
        end
        for (int j = 1; j <= 25; j++) begin
            cyc();
            checks++;
            if (ia.busy !== 4'b0000 || ia.done !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_after: offset %0d busy=%b done=%b, required 0000 0000",
                         j, ia.busy, ia.done);
            end
        end
    endtask

    task automatic test_div1_periodic();
        checks++;
        if (ib.tick !== 1'b1) begin
            errors++;
            $display("FAIL div1_tick: tick=%b, required 1", ib.tick);
        end
        ib.load = 1'b1; ib.load_ch = 2'd0; ib.load_value = 32'd1; ib.load_periodic = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            cyc();
            if (j == 1) ib.load = 1'b0;
            checks++;
            if (ib.busy !== 3'b001 || ib.done !== ((j >= 2) ? 3'b001 : 3'b000) || ib.done_any !== (j >= 2)) begin
                errors++;
                $display("FAIL div1_periodic: offset %0d busy=%b done=%b any=%b, required busy 001 done high from 2",
                         j, ib.busy, ib.done, ib.done_any);
            end
        end
        ib.abort = 1'b1;
        ib.abort_ch = 2'd0;
        for (int j = 21; j <= 24; j++) begin
            cyc();
            if (j == 21) ib.abort = 1'b0;
            checks++;
            if (ib.busy !== 3'b000 || ib.done !== 3'b000) begin
                errors++;
                $display("FAIL div1_abort: offset %0d busy=%b done=%b, required 000 000", j, ib.busy, ib.done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_back_to_back();
        test_corners();
        test_reset_mid();
        test_div1_periodic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
